// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the mem_system arbiter
// Contents: FSM state type, requester port IDs, default timeout constants.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_TO_W    = 7;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - 2-way round-robin / fixed-priority picker
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_req_d       data port requesting
//   i_req_i       fetch port requesting
//   i_take        the offered grant is accepted this cycle
//   o_valid       at least one requester, o_port is meaningful
//   o_port        chosen port (PORT_D / PORT_I)
module mem_arb_rr
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_d,
  input  logic i_req_i,
  input  logic i_take,
  output logic o_valid,
  output logic o_port
);

  // Winner of the most recent conflict. Uncontested grants leave it alone,
  // so alternation is decided only between genuinely competing requests.
  logic r_last;
  logic w_conflict;

  assign w_conflict = i_req_d & i_req_i;

  always_comb begin
    o_valid = i_req_d | i_req_i;
    o_port  = PORT_D;
    if (w_conflict) begin
      o_port = ((FIXED_PRIO != 0) || (r_last == PORT_I)) ? PORT_D : PORT_I;
    end else if (i_req_i) begin
      o_port = PORT_I;
    end
  end

  // Reset to I so that D wins the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= PORT_I;
    end else if (i_take && w_conflict) begin
      r_last <= o_port;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single mem_system
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   d_rd, d_wr, d_addr, d_data_in  data port request (held until d_done)
//   d_data_out, d_done, d_err      data port response (valid with d_done)
//   d_stall                        data port has an uncompleted request
//   i_rd, i_addr                   fetch port read request
//   i_data_out, i_done, i_err      fetch port response
//   i_stall                        fetch port has an uncompleted request
//   mem_addr, mem_data_in          to mem_system Addr / DataIn
//   mem_rd, mem_wr                 to mem_system Rd / Wr (only in BUSY)
//   mem_data_out, mem_done,
//   mem_stall, mem_err             from mem_system DataOut / Done / Stall / err
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 1,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TO_W       = DEF_TO_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_err,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_stall,
  output logic        i_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_err
);

  state_t r_state;
  state_t w_next;

  logic            r_owner;
  logic [15:0]     r_addr;
  logic [15:0]     r_wdata;
  logic [15:0]     r_rdata;
  logic            r_rd;
  logic            r_wr;
  logic            r_err;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_d_req;
  logic            w_i_req;
  logic            w_d_illegal;
  logic            w_gnt_valid;
  logic            w_gnt_port;
  logic            w_take;
  logic            w_timeout;
  logic [TO_W-1:0] w_to_inc;
  logic            w_unused_mem_stall;

  assign w_d_req     = d_rd | d_wr;
  assign w_i_req     = i_rd;
  assign w_d_illegal = d_rd & d_wr;
  assign w_take      = (r_state == ST_IDLE) & w_gnt_valid;

  // The counter is cleared on BUSY entry, so the incremented value equals
  // the number of BUSY cycles spent including the current one.
  assign w_to_inc  = r_to_cnt + TO_W'(1);
  assign w_timeout = (w_to_inc == TO_W'(TIMEOUT));

  // Stall is advisory to the pipeline; sequencing relies on mem_done only.
  assign w_unused_mem_stall = mem_stall;

  mem_arb_rr #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .i_req_d(w_d_req),
    .i_req_i(w_i_req),
    .i_take (w_take),
    .o_valid(w_gnt_valid),
    .o_port (w_gnt_port)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and all decoded outputs. mem_* and response outputs are
  // pure decodes of the state register, so an asynchronous reset drops
  // them immediately.
  always_comb begin
    w_next      = r_state;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    d_done      = 1'b0;
    d_err       = 1'b0;
    d_data_out  = '0;
    i_done      = 1'b0;
    i_err       = 1'b0;
    i_data_out  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          // A simultaneous read+write from D never reaches memory.
          w_next = ((w_gnt_port == PORT_D) && w_d_illegal) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        mem_rd      = r_rd;
        mem_wr      = r_wr;
        mem_addr    = r_addr;
        mem_data_in = r_wdata;
        if (mem_done || w_timeout) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
        if (r_owner == PORT_D) begin
          d_done     = 1'b1;
          d_err      = r_err;
          d_data_out = r_rdata;
        end else begin
          i_done     = 1'b1;
          i_err      = r_err;
          i_data_out = r_rdata;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign d_stall = w_d_req & ~d_done;
  assign i_stall = w_i_req & ~i_done;

  // Request latches, response capture and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner  <= PORT_D;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_owner  <= w_gnt_port;
            r_to_cnt <= '0;
            r_rdata  <= '0;
            if (w_gnt_port == PORT_D) begin
              r_addr  <= d_addr;
              r_wdata <= d_data_in;
              r_rd    <= d_rd;
              r_wr    <= d_wr;
              r_err   <= w_d_illegal;
            end else begin
              r_addr  <= i_addr;
              r_wdata <= '0;
              r_rd    <= 1'b1;
              r_wr    <= 1'b0;
              r_err   <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          r_to_cnt <= w_to_inc;
          // A completion arriving on the last allowed cycle beats the timeout.
          if (mem_done) begin
            r_rdata <= mem_data_out;
            r_err   <= mem_err;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance (u_rr0) signals
  logic        d_rd, d_wr, i_rd;
  logic [15:0] d_addr, d_data_in, i_addr;
  logic [15:0] d_data_out, i_data_out, mem_addr, mem_data_in, mem_data_out;
  logic        d_done, d_stall, d_err, i_done, i_stall, i_err;
  logic        mem_rd, mem_wr, mem_done, mem_err;

  // fixed-priority instance (u_fp1) signals
  logic        f_d_rd, f_d_wr, f_i_rd;
  logic [15:0] f_d_addr, f_d_data_in, f_i_addr;
  logic [15:0] f_d_data_out, f_i_data_out, f_mem_addr, f_mem_data_in, f_mem_data_out;
  logic        f_d_done, f_d_stall, f_d_err, f_i_done, f_i_stall, f_i_err;
  logic        f_mem_rd, f_mem_wr, f_mem_done, f_mem_err;

  logic        mem_stall_in = 1'b0;

  // memory model: Done after g_lat cycles of Rd/Wr (0 = never), data = addr ^ g_xor
  int          g_lat = 0;
  logic [15:0] g_xor = '0;
  logic        g_err = 1'b0;
  int          c0 = 0;
  int          c1 = 0;

  always @(posedge clk) c0 <= (mem_rd | mem_wr) ? c0 + 1 : 0;
  always @(posedge clk) c1 <= (f_mem_rd | f_mem_wr) ? c1 + 1 : 0;

  assign mem_done       = (mem_rd | mem_wr) && (g_lat != 0) && (c0 == g_lat - 1);
  assign mem_data_out   = mem_addr ^ g_xor;
  assign mem_err        = g_err;
  assign f_mem_done     = (f_mem_rd | f_mem_wr) && (g_lat != 0) && (c1 == g_lat - 1);
  assign f_mem_data_out = f_mem_addr ^ g_xor;
  assign f_mem_err      = g_err;

  mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TO), .TO_W(4)) u_rr0 (
    .clk(clk), .rst(rst),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall), .d_err(d_err),
    .i_rd(i_rd), .i_addr(i_addr),
    .i_data_out(i_data_out), .i_done(i_done), .i_stall(i_stall), .i_err(i_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall_in), .mem_err(mem_err)
  );

  mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TO), .TO_W(4)) u_fp1 (
    .clk(clk), .rst(rst),
    .d_rd(f_d_rd), .d_wr(f_d_wr), .d_addr(f_d_addr), .d_data_in(f_d_data_in),
    .d_data_out(f_d_data_out), .d_done(f_d_done), .d_stall(f_d_stall), .d_err(f_d_err),
    .i_rd(f_i_rd), .i_addr(f_i_addr),
    .i_data_out(f_i_data_out), .i_done(f_i_done), .i_stall(f_i_stall), .i_err(f_i_err),
    .mem_addr(f_mem_addr), .mem_data_in(f_mem_data_in), .mem_rd(f_mem_rd), .mem_wr(f_mem_wr),
    .mem_data_out(f_mem_data_out), .mem_done(f_mem_done), .mem_stall(mem_stall_in), .mem_err(f_mem_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    d_rd = 0; d_wr = 0; i_rd = 0; d_addr = '0; d_data_in = '0; i_addr = '0;
    f_d_rd = 0; f_d_wr = 0; f_i_rd = 0; f_d_addr = '0; f_d_data_in = '0; f_i_addr = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    g_lat = 0; g_err = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // single-transaction vectors; exp_done = negedges from issue to the done pulse
  typedef struct {
    string       name;
    logic        port;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] xr;
    int          lat;
    logic        merr;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  vec_t vtab[8];

  task automatic run_vec(input vec_t v);
    int busy;
    busy  = v.exp_done - 1;
    g_lat = v.lat; g_xor = v.xr; g_err = v.merr;
    if (v.port == PORT_D) begin
      d_rd = v.rd; d_wr = v.wr; d_addr = v.addr; d_data_in = v.wdata;
    end else begin
      i_rd = 1; i_addr = v.addr;
    end
    for (int j = 1; j <= v.exp_done + 1; j++) begin
      @(negedge clk);
      if (j <= busy) begin
        chk($sformatf("%s_busy%0d", v.name, j),
            {mem_rd, mem_wr, mem_addr, (v.port == PORT_D) ? d_stall : i_stall, d_done | i_done},
            {v.rd, v.wr, v.addr, 1'b1, 1'b0});
        if (v.wr) chk($sformatf("%s_wdata", v.name), mem_data_in, v.wdata);
      end else if (j == v.exp_done) begin
        if (v.port == PORT_D)
          chk($sformatf("%s_resp", v.name),
              {d_done, i_done, d_err, i_err, d_data_out, i_data_out, mem_rd, mem_wr, d_stall, i_stall},
              {1'b1, 1'b0, v.exp_err, 1'b0, v.exp_data, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        else
          chk($sformatf("%s_resp", v.name),
              {d_done, i_done, d_err, i_err, d_data_out, i_data_out, mem_rd, mem_wr, d_stall, i_stall},
              {1'b0, 1'b1, 1'b0, v.exp_err, 16'h0, v.exp_data, 1'b0, 1'b0, 1'b0, 1'b0});
        d_rd = 0; d_wr = 0; i_rd = 0;
      end else begin
        chk($sformatf("%s_pulse_end", v.name), {d_done, i_done, mem_rd, mem_wr}, 4'b0);
      end
    end
  endtask

  // D write held, I read raised one cycle later: D served, 1-cycle IDLE gap, then I
  task automatic wr_then_rd();
    logic [4:0] exp_seq [1:7];
    exp_seq[1] = 5'b01000; exp_seq[2] = 5'b01001; exp_seq[3] = 5'b00101;
    exp_seq[4] = 5'b00001; exp_seq[5] = 5'b10001; exp_seq[6] = 5'b10001;
    exp_seq[7] = 5'b00010;
    g_lat = 2; g_err = 0; g_xor = '0;
    d_wr = 1; d_addr = 16'h0020; d_data_in = 16'h1234;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      chk($sformatf("wr_rd_cyc%0d", j), {mem_rd, mem_wr, d_done, i_done, i_stall}, exp_seq[j]);
      if (j == 1) begin
        chk("wr_rd_wdata", {mem_addr, mem_data_in}, {16'h0020, 16'h1234});
        i_rd = 1; i_addr = 16'h0400;
      end
      if (j == 3) d_wr = 0;
      if (j == 5) chk("wr_rd_iaddr", mem_addr, 16'h0400);
      if (j == 7) i_rd = 0;
    end
    @(negedge clk);
  endtask

  // both ports request together on both instances; record who completes first
  task automatic pair_run(input int pair, input logic exp_rr, input logic exp_fp);
    int   n0, n1;
    logic first0, first1;
    n0 = 0; n1 = 0; first0 = PORT_D; first1 = PORT_D;
    g_lat = 2; g_err = 0;
    d_rd = 1; d_addr = 16'h0100; i_rd = 1; i_addr = 16'h0200;
    f_d_rd = 1; f_d_addr = 16'h0100; f_i_rd = 1; f_i_addr = 16'h0200;
    for (int j = 0; j < 30 && (n0 < 2 || n1 < 2); j++) begin
      @(negedge clk);
      if (d_done)   begin if (n0 == 0) first0 = PORT_D; n0++; d_rd = 0; end
      if (i_done)   begin if (n0 == 0) first0 = PORT_I; n0++; i_rd = 0; end
      if (f_d_done) begin if (n1 == 0) first1 = PORT_D; n1++; f_d_rd = 0; end
      if (f_i_done) begin if (n1 == 0) first1 = PORT_I; n1++; f_i_rd = 0; end
    end
    chk($sformatf("pair%0d_rr_count", pair), n0, 2);
    chk($sformatf("pair%0d_fp_count", pair), n1, 2);
    chk($sformatf("pair%0d_rr_first", pair), first0, exp_rr);
    chk($sformatf("pair%0d_fp_first", pair), first1, exp_fp);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic reset_mid_busy();
    g_lat = 0; g_err = 0;
    d_rd = 1; d_addr = 16'h0088;
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", {mem_rd, mem_addr}, {1'b1, 16'h0088});
    @(posedge clk);
    #2 rst = 0;
    #1 chk("rst_async_drop", {mem_rd, mem_wr, d_done, i_done, d_err, i_err, d_data_out}, '0);
    d_rd = 0;
    @(negedge clk);
    rst = 1;
    run_vec(vtab[0]);
  endtask

  // Transaction-level reference: the arbiter is a single server that frees up
  // one cycle after each response; conflicts alternate, starting with D.
  task automatic rand_phase(input int ncyc);
    int          t_free, d_due, i_due, lat, due;
    logic        lg, pick, merr, ill, tmo;
    bit          dp, ip, dg, ig;
    logic [15:0] d_exp, i_exp, e_data;
    logic        d_eerr, i_eerr, e_err;
    int          r;
    t_free = 0; lg = PORT_I; dp = 0; ip = 0; dg = 0; ig = 0;
    d_due = -1; i_due = -1; d_exp = '0; i_exp = '0; d_eerr = 0; i_eerr = 0;
    g_xor = 16'($urandom);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk("rnd_done", {d_done, i_done}, {dg && (k == d_due), ig && (k == i_due)});
      if (dg && k == d_due) begin
        chk("rnd_d_resp", {d_data_out, d_err}, {d_exp, d_eerr});
        dp = 0; dg = 0; d_rd = 0; d_wr = 0;
      end
      if (ig && k == i_due) begin
        chk("rnd_i_resp", {i_data_out, i_err}, {i_exp, i_eerr});
        ip = 0; ig = 0; i_rd = 0;
      end
      chk("rnd_stall", {d_stall, i_stall}, {dp, ip});
      if (!dp && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        dp = 1; d_rd = (r < 5) || (r == 9); d_wr = (r >= 5);
        d_addr = 16'($urandom); d_data_in = 16'($urandom);
      end
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; i_rd = 1; i_addr = 16'($urandom);
      end
      if (k >= t_free && (dp || ip)) begin
        if (dp && ip) begin
          pick = (lg == PORT_I) ? PORT_D : PORT_I;
          lg   = pick;
        end else begin
          pick = dp ? PORT_D : PORT_I;
        end
        lat  = $urandom_range(1, 10);
        merr = ($urandom_range(0, 3) == 0);
        tmo  = (lat > TO);
        g_lat = tmo ? 0 : lat; g_err = merr;
        ill = (pick == PORT_D) && d_rd && d_wr;
        if (ill) begin
          due = k + 1; e_data = '0; e_err = 1;
        end else begin
          due    = k + (tmo ? TO : lat) + 1;
          e_data = tmo ? 16'h0 : (((pick == PORT_D) ? d_addr : i_addr) ^ g_xor);
          e_err  = tmo ? 1'b1 : merr;
        end
        t_free = due + 1;
        if (pick == PORT_D) begin dg = 1; d_due = due; d_exp = e_data; d_eerr = e_err; end
        else                begin ig = 1; i_due = due; i_exp = e_data; i_eerr = e_err; end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vtab[0] = '{"d_read",       PORT_D, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEFF, 4, 1'b0, 16'hBEEF, 1'b0, 5};
    vtab[1] = '{"d_write",      PORT_D, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 2, 1'b0, 16'h0020, 1'b0, 3};
    vtab[2] = '{"i_best",       PORT_I, 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h1111, 1, 1'b0, 16'h1211, 1'b0, 2};
    vtab[3] = '{"d_timeout",    PORT_D, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 0, 1'b0, 16'h0000, 1'b1, 9};
    vtab[4] = '{"i_at_limit",   PORT_I, 1'b1, 1'b0, 16'h0050, 16'h0000, 16'hFFFF, 8, 1'b0, 16'hFFAF, 1'b0, 9};
    vtab[5] = '{"d_illegal",    PORT_D, 1'b1, 1'b1, 16'h0060, 16'h5555, 16'h0000, 3, 1'b0, 16'h0000, 1'b1, 1};
    vtab[6] = '{"i_memerr",     PORT_I, 1'b1, 1'b0, 16'h0070, 16'h0000, 16'h00F0, 3, 1'b1, 16'h0080, 1'b1, 4};
    vtab[7] = '{"d_memerr_lat7",PORT_D, 1'b1, 1'b0, 16'hABCD, 16'h0000, 16'h0F0F, 7, 1'b1, 16'hA4C2, 1'b1, 8};

    idle_inputs();
    rst = 0;
    #12;
    chk("reset_outputs",
        {mem_rd, mem_wr, mem_addr, mem_data_in, d_done, d_err, d_stall, d_data_out,
         i_done, i_err, i_stall},
        '0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("idle_outputs", {mem_rd, mem_wr, d_done, i_done, i_data_out, d_data_out}, '0);

    for (int n = 0; n < 8; n++) run_vec(vtab[n]);

    wr_then_rd();

    apply_reset();
    pair_run(1, PORT_D, PORT_D);
    pair_run(2, PORT_I, PORT_D);

    reset_mid_busy();

    apply_reset();
    rand_phase(600);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
